// File: rtl/mod12_up_counter.sv
// ---------------------------------------------------------------------------
// mod12_up_counter
//   Synchronous 4-bit binary up counter with a programmable modulus
//   (default 12). Counts 0..MODULUS-1, then wraps to 0. Used as a
//   divide-by-MODULUS or as a small sequence generator.
//
// Parameters
//   MODULUS : count length, legal range 2..16. The state width is fixed at 4.
//
// Ports
//   clk : rising-edge clock; every state change happens on posedge clk
//   clr : synchronous active-high clear; clr=1 forces the count to 0
//   Qa  : count bit 0 (LSB), registered
//   Qb  : count bit 1, registered
//   Qc  : count bit 2, registered
//   Qd  : count bit 3 (MSB), registered
// ---------------------------------------------------------------------------
module mod12_up_counter #(
    parameter int unsigned MODULUS = 12
) (
    input  logic clk,
    input  logic clr,
    output logic Qa,
    output logic Qb,
    output logic Qc,
    output logic Qd
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MODULUS - 1);

    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;

    // Next-state: clear wins, then wrap at the last count. Values above the
    // last count cannot be reached from a cleared state, but if one appears
    // it recovers to 0 in one edge rather than counting through 15.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (q_q >= CNT_LAST) begin
            q_d = '0;
        end else begin
            q_d = q_q + CNT_W'(1);
        end
    end

    // Count register; clear is sampled synchronously with the clock.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    // Outputs come straight from the flops, no combinational path from clr.
    assign Qa = q_q[0];
    assign Qb = q_q[1];
    assign Qc = q_q[2];
    assign Qd = q_q[3];

endmodule

// File: tb/tb_mod12_up_counter.sv
module tb_mod12_up_counter;

    logic       clk;
    logic       clr;
    logic       Qa;
    logic       Qb;
    logic       Qc;
    logic       Qd;
    logic [3:0] q_obs;

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned edges_since_rel;

    assign q_obs = {Qd, Qc, Qb, Qa};

    mod12_up_counter #(.MODULUS(12)) dut (
        .clk (clk),
        .clr (clr),
        .Qa  (Qa),
        .Qb  (Qb),
        .Qc  (Qc),
        .Qd  (Qd)
    );

    // 10 ns period, first posedge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // clr high through the 5 ns edge, released at 10 ns.
    task automatic test_reset();
        clr = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (q_obs !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_5ns: got %b expected 0000", q_obs);
        end
        #4;
        clr = 1'b0;
        edges_since_rel = 0;
    endtask

    // Edges at 15..115 ns give 1..11.
    task automatic test_count_up();
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            edges_since_rel++;
            n_vec++;
            if (q_obs !== 4'(k)) begin
                n_err++;
                $display("FAIL count_up[%0d] t=%0t: got %b expected %b", k, $time, q_obs, 4'(k));
            end
        end
    endtask

    // 125 ns edge wraps 1011 -> 0000, 135 ns gives 0001.
    task automatic test_wrap();
        @(posedge clk);
        #1;
        edges_since_rel++;
        n_vec++;
        if (q_obs !== 4'b0000) begin
            n_err++;
            $display("FAIL wrap_125ns: got %b expected 0000", q_obs);
        end
        @(posedge clk);
        #1;
        edges_since_rel++;
        n_vec++;
        if (q_obs !== 4'b0001) begin
            n_err++;
            $display("FAIL wrap_135ns: got %b expected 0001", q_obs);
        end
    endtask

    // Free run through 195 ns, checked against (edges since release) mod 12.
    task automatic test_free_run();
        while ($time < 195) begin
            @(posedge clk);
            #1;
            edges_since_rel++;
            n_vec++;
            if (q_obs !== 4'(edges_since_rel % 12) || q_obs > 4'd11) begin
                n_err++;
                $display("FAIL free_run t=%0t: got %b expected %b", $time, q_obs,
                         4'(edges_since_rel % 12));
            end
        end
        n_vec++;
        if (q_obs !== 4'b0111) begin
            n_err++;
            $display("FAIL free_run_195ns: got %b expected 0111", q_obs);
        end
    endtask

    // Advance until the model reaches 0110, then pulse clr for one edge.
    task automatic test_clear_mid_count();
        int budget;
        budget = 0;
        while ((edges_since_rel % 12) != 6 && budget < 20) begin
            @(posedge clk);
            #1;
            edges_since_rel++;
            budget++;
        end
        n_vec++;
        if (q_obs !== 4'b0110) begin
            n_err++;
            $display("FAIL pre_clear_value: got %b expected 0110", q_obs);
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (q_obs !== 4'b0000) begin
            n_err++;
            $display("FAIL clear_mid: got %b expected 0000", q_obs);
        end
        clr = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (q_obs !== 4'b0001) begin
            n_err++;
            $display("FAIL clear_mid_next: got %b expected 0001", q_obs);
        end
    endtask

    // clr held for three edges keeps the count at 0000.
    task automatic test_hold_clear();
        clr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (q_obs !== 4'b0000) begin
                n_err++;
                $display("FAIL hold_clear[%0d]: got %b expected 0000", k, q_obs);
            end
        end
        clr = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (q_obs !== 4'b0001) begin
            n_err++;
            $display("FAIL hold_clear_release: got %b expected 0001", q_obs);
        end
    endtask

    // clr pulse between edges must not disturb the count.
    task automatic test_glitch();
        #2;
        clr = 1'b1;
        #2;
        clr = 1'b0;
        n_vec++;
        if (q_obs !== 4'b0001) begin
            n_err++;
            $display("FAIL glitch_between_edges: got %b expected 0001", q_obs);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (q_obs !== 4'b0010) begin
            n_err++;
            $display("FAIL glitch_next_edge: got %b expected 0010", q_obs);
        end
    endtask

    // clr asserted on the wrap edge: 0000, then counting restarts at 0001.
    task automatic test_clear_on_wrap();
        for (int k = 3; k <= 11; k++) begin
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (q_obs !== 4'b1011) begin
            n_err++;
            $display("FAIL pre_wrap_value: got %b expected 1011", q_obs);
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        n_vec++;
        if (q_obs !== 4'b0000) begin
            n_err++;
            $display("FAIL clear_on_wrap: got %b expected 0000", q_obs);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (q_obs !== 4'b0001) begin
            n_err++;
            $display("FAIL clear_on_wrap_next: got %b expected 0001", q_obs);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        edges_since_rel = 0;
        clr = 1'b1;
        test_reset();
        test_count_up();
        test_wrap();
        test_free_run();
        test_clear_mid_count();
        test_hold_clear();
        test_glitch();
        test_clear_on_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
